// File: rtl/sprite_memory_writer.sv
// Write-side loader for the sprite memory bank: validates a load command, then turns a
// valid/ready byte stream into sequential SRAM write strobes, always yielding to display reads.
module sprite_memory_writer #(
  parameter int ELEMENTS   = 5,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ELEMENTS-1:0]   cmd_element,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic [ADDR_WIDTH-1:0] cmd_length,
  input  logic                  abort,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  read_enable,
  output logic                  wr_enable,
  output logic [ELEMENTS-1:0]   wr_element,
  output logic [ADDR_WIDTH-1:0] wr_address,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] words_written
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                state_q, state_d;
  logic                  pending_q, pending_d;
  logic                  error_q, error_d;
  logic [ELEMENTS-1:0]   elem_q, elem_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic [ADDR_WIDTH-1:0] acc_q, acc_d;
  logic [ADDR_WIDTH-1:0] words_q, words_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic [ADDR_WIDTH:0]   depth;
  logic [ADDR_WIDTH:0]   cmd_end;
  logic                  elem_ok;
  logic                  cmd_ok;
  logic                  xfer;
  logic                  last_write;

  // Unknown element codes map to depth 0 so they can never pass the bounds test either.
  always_comb begin
    depth   = '0;
    elem_ok = 1'b1;
    case (cmd_element)
      ELEMENTS'(1): depth = (ADDR_WIDTH+1)'(625);
      ELEMENTS'(2): depth = (ADDR_WIDTH+1)'(256);
      ELEMENTS'(3): depth = (ADDR_WIDTH+1)'(400);
      ELEMENTS'(4): depth = (ADDR_WIDTH+1)'(10000);
      ELEMENTS'(5): depth = (ADDR_WIDTH+1)'(625);
      default:      elem_ok = 1'b0;
    endcase
  end

  // Sum carried one bit wider so a base near the top of the address space cannot wrap.
  assign cmd_end = {1'b0, cmd_base} + {1'b0, cmd_length};
  assign cmd_ok  = elem_ok && (cmd_length != '0) && (cmd_end <= depth);

  assign in_ready      = (state_q == LOAD) && !read_enable && (acc_q < len_q);
  assign xfer          = in_valid && in_ready;
  assign wr_enable     = pending_q && !read_enable;
  assign last_write    = (words_q == len_q - ADDR_WIDTH'(1));
  assign done          = wr_enable && (state_q == LOAD) && !abort && last_write;
  assign busy          = (state_q == LOAD);
  assign error         = error_q;
  assign wr_element    = elem_q;
  assign wr_address    = addr_q;
  assign wr_data       = data_q;
  assign words_written = words_q;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    error_d   = error_q;
    elem_d    = elem_q;
    base_d    = base_q;
    len_d     = len_q;
    acc_d     = acc_q;
    words_d   = words_q;
    addr_d    = addr_q;
    data_d    = data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (cmd_ok) begin
            elem_d    = cmd_element;
            base_d    = cmd_base;
            len_d     = cmd_length;
            acc_d     = '0;
            words_d   = '0;
            error_d   = 1'b0;
            pending_d = 1'b0;
            state_d   = LOAD;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (wr_enable) begin
          words_d   = words_q + ADDR_WIDTH'(1);
          pending_d = 1'b0;
        end
        // A write retiring in the abort cycle did reach the SRAM, so it stays counted.
        if (abort) begin
          pending_d = 1'b0;
          state_d   = IDLE;
        end else begin
          if (xfer) begin
            pending_d = 1'b1;
            addr_d    = base_q + acc_q;
            data_d    = in_data;
            acc_d     = acc_q + ADDR_WIDTH'(1);
          end
          if (done) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      error_q   <= 1'b0;
      elem_q    <= '0;
      base_q    <= '0;
      len_q     <= '0;
      acc_q     <= '0;
      words_q   <= '0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      error_q   <= error_d;
      elem_q    <= elem_d;
      base_q    <= base_d;
      len_q     <= len_d;
      acc_q     <= acc_d;
      words_q   <= words_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

endmodule

// File: doc/sprite_memory_writer.md
Name: sprite_memory_writer

Overview:
- Loader on the write side of the sprite memory bank; the display path reads that bank.
- Accepts a load command (element id, base address, pixel count) and a byte stream of 8-bit palette indices over a valid/ready handshake.
- Issues sequential write strobes into the selected element's sprite SRAM.
- Display reads always take priority over writes.
- Bounds-checks every command against the fixed sprite depths: element1 625, element2 256, element3 400, element4 10000, element5 625.

Parameters:
- ELEMENTS, 5, width of element select fields; legal element codes are 1..5.
- ADDR_WIDTH, 16, sprite address width; covers the 10000-entry background.
- DATA_WIDTH, 8, width of one stored pixel index.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- cmd_element  in  ELEMENTS  target sprite element code (1..5).
- cmd_base  in  ADDR_WIDTH  first address to write.
- cmd_length  in  ADDR_WIDTH  number of pixels to write.
- abort  in  1  cancels the active load.
- in_valid  in  1  stream byte valid.
- in_data  in  DATA_WIDTH  stream byte (palette index).
- in_ready  out  1  loader accepts in_data this cycle.
- read_enable  in  1  display is reading the sprite bank this cycle.
- wr_enable  out  1  write strobe to the sprite SRAM.
- wr_element  out  ELEMENTS  element receiving the write.
- wr_address  out  ADDR_WIDTH  write address.
- wr_data  out  DATA_WIDTH  write data.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse on the last write.
- error  out  1  sticky; set when a command is rejected.
- words_written  out  ADDR_WIDTH  writes retired in the current or last load.

Behaviour:
- Reset (async, reset=0) clears the following:
  - state=IDLE; pending=0; all wr_* outputs to 0.
  - busy=0, done=0, error=0, words_written=0.
  - Any pending write is dropped.
- States: IDLE, LOAD, DONE.
- IDLE, on start, validate the command:
  - element must be in 1..5.
  - cmd_length must be nonzero.
  - cmd_base+cmd_length must not exceed DEPTH(element); compute the sum at ADDR_WIDTH+1 bits with no wrap.
  - Valid command: latch element/base/length; set accept_count=0 and words_written=0; clear error; go to LOAD. busy=1 from the next cycle.
  - Invalid command: error=1 from the next cycle; stay in IDLE; busy stays 0.
- start is ignored outside IDLE.
- in_ready = (state==LOAD) && !read_enable && (accept_count < length). It is combinational.
- A transfer occurs when in_valid && in_ready. On the following edge:
  - pending=1.
  - wr_address_reg = base + accept_count.
  - wr_data_reg = in_data.
  - accept_count increments.
- wr_enable = pending && !read_enable. It is combinational, so a write is never issued in a read cycle.
- A pending write retires on any edge where wr_enable=1. pending then clears unless a new transfer occurs in the same cycle, in which case the registers reload.
- With read_enable held low, throughput is 1 byte per clock and write latency is 1 cycle after acceptance.
- With read_enable high:
  - in_ready=0 and wr_enable=0.
  - The pending write, address and data hold unchanged.
- words_written increments on each retired write.
- When the retiring write is number `length`, done=1 in that same cycle (combinational with wr_enable). The state then moves to DONE for one cycle (busy=0) and then to IDLE.
- abort in LOAD: IDLE on the next edge. The pending write is dropped, error is unchanged, done is not pulsed, and words_written keeps its retired count.
- abort while read_enable holds a write: abort wins.
- wr_element equals the latched element throughout LOAD.

Test Plan:
- Valid load, read_enable=0: start element=2, base=0, length=4; stream 0x11, 0x22, 0x33, 0x44 back-to-back → wr_enable on 4 consecutive cycles, addresses 0..3 with matching data, done pulse on the 4th write, words_written=4, busy falls after.
- Read contention: load element=5, base=10, length=3; assert read_enable for 2 cycles while the first byte is pending → wr_enable=0 and in_ready=0 during those cycles; address 10 data held; all 3 writes land at 10, 11, 12 after release.
- Bounds reject: start element=2, base=250, length=7 (257>256) → error=1, busy stays 0, no wr_enable. Then start element=2, base=250, length=6 → accepted, error clears.
- Bad element / zero length: start element=0 → error=1; start element=6 → error=1; start length=0 → error=1; no writes issued in any case.
- Abort: load element=4, base=9990, length=10; abort after 3 writes → IDLE next cycle, no done, words_written=3. Start again in the following cycle → accepted.
- Async reset mid-load: reset=0 asynchronously with a write pending → wr_enable drops immediately, all outputs 0. After release the block is in IDLE and accepts a new command.
